// File: rtl/alu_flag_unit.sv
// ---------------------------------------------------------------------------
// alu_flag_unit
//
// Registered NZCV flag unit sitting between the ALU and the control/branch
// unit. Derives N/Z/C/V from the ALU result and operands, holds them in a
// flag register that is written only on flag-setting instructions, evaluates
// 4-bit condition codes against the held flags and keeps a small LIFO of
// saved flags for interrupt entry/exit.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   s             set-flags enable for this cycle's result
//   arith         1: update NZCV, 0: update N,Z only (C,V hold)
//   sub           1: result = in1 - in2, 0: result = in1 + in2
//   in1, in2      ALU operands (in2 un-inverted)
//   result        ALU result, bit WIDTH is the adder carry-out
//   push, pop     save current flags / restore flags from stack top
//   err_clr       clear the sticky stack error
//   cond          condition code to evaluate
//   flags         registered {N,Z,C,V}
//   cond_pass     cond evaluated against flags (combinational)
//   depth         number of valid stack entries
//   stack_full    depth == STACK_DEPTH
//   stack_empty   depth == 0
//   stack_err     sticky overflow/underflow indicator
// ---------------------------------------------------------------------------
module alu_flag_unit #(
    parameter int WIDTH       = 32,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             s,
    input  logic                             arith,
    input  logic                             sub,
    input  logic [WIDTH-1:0]                 in1,
    input  logic [WIDTH-1:0]                 in2,
    input  logic [WIDTH:0]                   result,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             err_clr,
    input  logic [3:0]                       cond,
    output logic [3:0]                       flags,
    output logic                             cond_pass,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             stack_err
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int M  = WIDTH - 1;

    logic [3:0]    flags_q, flags_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic [3:0]    stack_q [STACK_DEPTH];

    logic [3:0]    calc_flags;
    logic          full, empty;
    logic          do_push, do_pop, err_event;
    logic [IW-1:0] wr_idx, rd_idx;
    logic          unused_bits;

    // Only the operand sign bits matter for overflow detection.
    assign unused_bits = ^{in1[WIDTH-2:0], in2[WIDTH-2:0]};

    // Flag computation: {N,Z,C,V}. For subtraction C is NOT-borrow, and the
    // overflow test compares signs against in2 un-inverted, hence the flip.
    always_comb begin
        calc_flags    = 4'b0000;
        calc_flags[3] = result[M];
        calc_flags[2] = (result[M:0] == '0);
        calc_flags[1] = result[WIDTH];
        if (sub) begin
            calc_flags[0] = (in1[M] != in2[M]) && (result[M] != in1[M]);
        end else begin
            calc_flags[0] = (in1[M] == in2[M]) && (result[M] != in1[M]);
        end
    end

    assign full   = (depth_q == DW'(STACK_DEPTH));
    assign empty  = (depth_q == '0);
    assign wr_idx = IW'(depth_q);
    assign rd_idx = IW'(depth_q - DW'(1));

    // A simultaneous push and pop cancel out: nothing moves, no error.
    assign do_push   = push && !pop && !full;
    assign do_pop    = pop && !push && !empty;
    assign err_event = (push && !pop && full) || (pop && !push && empty);

    always_comb begin
        flags_d = flags_q;
        depth_d = depth_q;
        err_d   = err_q;

        if (do_pop) begin
            // Restoring from the stack overrides any same-cycle flag set.
            flags_d = stack_q[rd_idx];
            depth_d = depth_q - DW'(1);
        end else if (s) begin
            if (arith) begin
                flags_d = calc_flags;
            end else begin
                flags_d = {calc_flags[3:2], flags_q[1:0]};
            end
        end

        if (do_push) begin
            depth_d = depth_q + DW'(1);
        end

        // A new error takes precedence over a coincident clear.
        if (err_event) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack storage saves the pre-update flags; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_q[wr_idx] <= flags_q;
        end
    end

    // Condition evaluation against the held flags.
    always_comb begin
        logic n, z, c, v;
        n         = flags_q[3];
        z         = flags_q[2];
        c         = flags_q[1];
        v         = flags_q[0];
        cond_pass = 1'b1;
        case (cond)
            4'd0:    cond_pass = z;
            4'd1:    cond_pass = !z;
            4'd2:    cond_pass = c;
            4'd3:    cond_pass = !c;
            4'd4:    cond_pass = n;
            4'd5:    cond_pass = !n;
            4'd6:    cond_pass = v;
            4'd7:    cond_pass = !v;
            4'd8:    cond_pass = c && !z;
            4'd9:    cond_pass = !c || z;
            4'd10:   cond_pass = (n == v);
            4'd11:   cond_pass = (n != v);
            4'd12:   cond_pass = !z && (n == v);
            4'd13:   cond_pass = z || (n != v);
            default: cond_pass = 1'b1;
        endcase
    end

    assign flags       = flags_q;
    assign depth       = depth_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err_q;

endmodule
